itwd_mul01: RTL and testbench

ITWD_MUL01 -- requirements
Module: itwd_mul01

---
 rtl/itwd_mul01_if.sv | 40 ++++
 rtl/itwd_mul01.sv | 161 ++++++++++++++++
 tb/tb_itwd_mul01.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/itwd_mul01_if.sv
// Beat interface for the stage-01 inverse-twiddle multiplier.
// It carries the input beat (valid, start of block, sum and diff branches)
// and the twiddled output beat. The design sits on the slave side.
interface itwd_mul01_if #(
    parameter int WIDTH = 9,
    parameter int LANES = 16
);
    // Input beat: samples are <5.6>, WIDTH+2 bits wide
    logic                   i_valid;
    logic                   i_sof;
    logic signed [WIDTH+1:0] i_01bfly_sum_re  [LANES];
    logic signed [WIDTH+1:0] i_01bfly_sum_im  [LANES];
    logic signed [WIDTH+1:0] i_01bfly_diff_re [LANES];
    logic signed [WIDTH+1:0] i_01bfly_diff_im [LANES];

    // Output beat: samples are <7.6>, WIDTH+4 bits wide
    logic                   o_valid;
    logic signed [WIDTH+3:0] o_sum_re  [LANES];
    logic signed [WIDTH+3:0] o_sum_im  [LANES];
    logic signed [WIDTH+3:0] o_diff_re [LANES];
    logic signed [WIDTH+3:0] o_diff_im [LANES];

    // Source of input beats and sink of results
    modport master (
        output i_valid, i_sof,
        output i_01bfly_sum_re, i_01bfly_sum_im,
        output i_01bfly_diff_re, i_01bfly_diff_im,
        input  o_valid,
        input  o_sum_re, o_sum_im, o_diff_re, o_diff_im
    );

    // The multiplier itself
    modport slave (
        input  i_valid, i_sof,
        input  i_01bfly_sum_re, i_01bfly_sum_im,
        input  i_01bfly_diff_re, i_01bfly_diff_im,
        output o_valid,
        output o_sum_re, o_sum_im, o_diff_re, o_diff_im
    );
endinterface

// File: rtl/itwd_mul01.sv
// Stage-01 inverse (conjugate) twiddle multiplier.
// The diff branch is rotated by 1, +j, 1 or (181+181j)/256 depending on
// which group of GRP_BEATS beats within the 16-beat block it falls in.
// The sum branch is only sign-extended. Two register stages, no stalls.
module itwd_mul01 #(
    parameter int WIDTH     = 9,
    parameter int LANES     = 16,
    parameter int GRP_BEATS = 4
) (
    input  logic          clk,
    input  logic          rstn,
    itwd_mul01_if.slave   bus
);

    localparam int BLK_BEATS = 4 * GRP_BEATS;
    localparam int CW        = $clog2(BLK_BEATS);
    localparam int IW        = WIDTH + 2;
    localparam int OW        = WIDTH + 4;
    localparam int PW        = WIDTH + 12;

    // cos(pi/4) scaled by 256
    localparam logic signed [PW-1:0] TW_C45_COEF = PW'(181);

    // Twiddle selector: 0 and 2 are unity, 1 is +j, 3 is the 45-degree rotation
    typedef enum logic [1:0] {
        TW_ONE_A = 2'd0,
        TW_POS_J = 2'd1,
        TW_ONE_B = 2'd2,
        TW_C45   = 2'd3
    } tw_idx_e;

    logic [CW-1:0] beat_cnt;
    logic [1:0]    grp_idx;
    tw_idx_e       cur_idx;

    // Stage 1 registers
    logic                 s1_valid;
    tw_idx_e              s1_idx;
    logic signed [PW-1:0] s1_re_pa [LANES];
    logic signed [PW-1:0] s1_re_pb [LANES];
    logic signed [PW-1:0] s1_im_pa [LANES];
    logic signed [PW-1:0] s1_im_pb [LANES];
    logic signed [OW-1:0] s1_a     [LANES];
    logic signed [OW-1:0] s1_b     [LANES];
    logic signed [OW-1:0] s1_nb    [LANES];
    logic signed [IW-1:0] s1_sum_re [LANES];
    logic signed [IW-1:0] s1_sum_im [LANES];

    // Stage 2 next-state values
    logic signed [OW-1:0] d_re_nxt [LANES];
    logic signed [OW-1:0] d_im_nxt [LANES];

    // Beat position within the block; advances on accepted beats only, a
    // start-of-block beat counts as position 0 so the next one is position 1
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: registers take <= so every flop samples pre-edge values
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (bus.i_valid) begin
            if (bus.i_sof)
                beat_cnt <= CW'(1);
            else if (beat_cnt == CW'(BLK_BEATS - 1))
                beat_cnt <= '0;
            else
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign grp_idx = 2'(beat_cnt / CW'(GRP_BEATS));

    // Twiddle index of the beat presented now; start of block forces group 0
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred
        cur_idx = TW_ONE_A;
        if (!bus.i_sof)
            cur_idx = tw_idx_e'(grp_idx);
    end

    // Stage 1: multiply by 181, keep a, b and -b extended to output width
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_idx   <= TW_ONE_A;
            // NOTE: these arrays are plain pipeline flops, not RAM, so they are reset
            for (int l = 0; l < LANES; l++) begin
                s1_re_pa[l]  <= '0;
                s1_re_pb[l]  <= '0;
                s1_im_pa[l]  <= '0;
                s1_im_pb[l]  <= '0;
                s1_a[l]      <= '0;
                s1_b[l]      <= '0;
                s1_nb[l]     <= '0;
                s1_sum_re[l] <= '0;
                s1_sum_im[l] <= '0;
            end
        end else begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_idx <= cur_idx;
                for (int l = 0; l < LANES; l++) begin
                    s1_re_pa[l]  <= PW'(bus.i_01bfly_diff_re[l]) * TW_C45_COEF;
                    s1_re_pb[l]  <= PW'(bus.i_01bfly_diff_im[l]) * TW_C45_COEF;
                    s1_im_pa[l]  <= PW'(bus.i_01bfly_diff_re[l]) * TW_C45_COEF;
                    s1_im_pb[l]  <= PW'(bus.i_01bfly_diff_im[l]) * TW_C45_COEF;
                    s1_a[l]      <= OW'(bus.i_01bfly_diff_re[l]);
                    s1_b[l]      <= OW'(bus.i_01bfly_diff_im[l]);
                    s1_nb[l]     <= -OW'(bus.i_01bfly_diff_im[l]);
                    s1_sum_re[l] <= bus.i_01bfly_sum_re[l];
                    s1_sum_im[l] <= bus.i_01bfly_sum_im[l];
                end
            end
        end
    end

    // Combine products, floor-shift by 8 and pick the result for this index;
    // the 45-degree result always fits OW bits, so the size cast only drops sign copies
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            d_re_nxt[l] = s1_a[l];
            d_im_nxt[l] = s1_b[l];
            case (s1_idx)
                TW_POS_J: begin
                    d_re_nxt[l] = s1_nb[l];
                    d_im_nxt[l] = s1_a[l];
                end
                TW_C45: begin
                    d_re_nxt[l] = OW'((s1_re_pa[l] - s1_re_pb[l]) >>> 8);
                    d_im_nxt[l] = OW'((s1_im_pa[l] + s1_im_pb[l]) >>> 8);
                end
                default: begin
                    d_re_nxt[l] = s1_a[l];
                    d_im_nxt[l] = s1_b[l];
                end
            endcase
        end
    end

    // Stage 2: output registers, hold their contents between valid beats
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.o_valid <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                bus.o_sum_re[l]  <= '0;
                bus.o_sum_im[l]  <= '0;
                bus.o_diff_re[l] <= '0;
                bus.o_diff_im[l] <= '0;
            end
        end else begin
            bus.o_valid <= s1_valid;
            if (s1_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    bus.o_sum_re[l]  <= OW'(s1_sum_re[l]);
                    bus.o_sum_im[l]  <= OW'(s1_sum_im[l]);
                    bus.o_diff_re[l] <= d_re_nxt[l];
                    bus.o_diff_im[l] <= d_im_nxt[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_itwd_mul01.sv
// Self-checking bench for itwd_mul01: directed twiddle, floor, extreme,
// gapped-valid, resync and reset scenarios followed by random traffic,
// all compared against a beat-level reference model.
module tb_itwd_mul01;

    localparam int WIDTH     = 9;
    localparam int LANES     = 16;
    localparam int GRP_BEATS = 4;
    localparam int BLK       = 4 * GRP_BEATS;
    localparam int IW        = WIDTH + 2;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    itwd_mul01_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    itwd_mul01 #(.WIDTH(WIDTH), .LANES(LANES), .GRP_BEATS(GRP_BEATS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pos;                 // position of the next beat within its block
    int exp_q[$];              // expected results, 4 values per lane per beat
    bit hist0, hist1;          // i_valid seen one and two edges ago
    int last_out [LANES][4];   // most recent expected output beat

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor256(input int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        hist0 = 1'b0;
        hist1 = 1'b0;
        m_pos = 0;
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < 4; k++)
                last_out[l][k] = 0;
    endtask

    // Compute the expected result of the beat on the bus right now
    task automatic model_accept();
        int grp, a, b, re, im;
        grp   = bus.i_sof ? 0 : m_pos / GRP_BEATS;
        m_pos = bus.i_sof ? 1 : (m_pos + 1) % BLK;
        for (int l = 0; l < LANES; l++) begin
            a = int'(bus.i_01bfly_diff_re[l]);
            b = int'(bus.i_01bfly_diff_im[l]);
            case (grp)
                1:       begin re = -b; im = a; end
                3:       begin re = floor256(181 * a - 181 * b);
                               im = floor256(181 * a + 181 * b); end
                default: begin re = a; im = b; end
            endcase
            exp_q.push_back(int'(bus.i_01bfly_sum_re[l]));
            exp_q.push_back(int'(bus.i_01bfly_sum_im[l]));
            exp_q.push_back(re);
            exp_q.push_back(im);
        end
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge
    task automatic tick(input string tag);
        @(posedge clk);
        if (rstn) begin
            hist1 = hist0;
            hist0 = bus.i_valid;
            if (bus.i_valid) model_accept();
        end
        @(negedge clk);
        check($sformatf("%s o_valid", tag), int'(bus.o_valid), int'(hist1));
        if (hist1) begin
            if (exp_q.size() < 4 * LANES) begin
                check($sformatf("%s queue underrun", tag), exp_q.size(), 4 * LANES);
            end else begin
                for (int l = 0; l < LANES; l++)
                    for (int k = 0; k < 4; k++)
                        last_out[l][k] = exp_q.pop_front();
            end
        end
        for (int l = 0; l < LANES; l++) begin
            check($sformatf("%s sum_re l%0d", tag, l),  int'(bus.o_sum_re[l]),  last_out[l][0]);
            check($sformatf("%s sum_im l%0d", tag, l),  int'(bus.o_sum_im[l]),  last_out[l][1]);
            check($sformatf("%s diff_re l%0d", tag, l), int'(bus.o_diff_re[l]), last_out[l][2]);
            check($sformatf("%s diff_im l%0d", tag, l), int'(bus.o_diff_im[l]), last_out[l][3]);
        end
    endtask

    task automatic drive(input bit v, input bit s, input int sr, input int si,
                         input int dr, input int di);
        bus.i_valid = v;
        bus.i_sof   = s;
        for (int l = 0; l < LANES; l++) begin
            bus.i_01bfly_sum_re[l]  = IW'(sr);
            bus.i_01bfly_sum_im[l]  = IW'(si);
            bus.i_01bfly_diff_re[l] = IW'(dr);
            bus.i_01bfly_diff_im[l] = IW'(di);
        end
    endtask

    task automatic drive_rand(input bit v, input bit s);
        bus.i_valid = v;
        bus.i_sof   = s;
        for (int l = 0; l < LANES; l++) begin
            bus.i_01bfly_sum_re[l]  = IW'(int'($urandom_range(0, 2047)) - 1024);
            bus.i_01bfly_sum_im[l]  = IW'(int'($urandom_range(0, 2047)) - 1024);
            bus.i_01bfly_diff_re[l] = IW'(int'($urandom_range(0, 2047)) - 1024);
            bus.i_01bfly_diff_im[l] = IW'(int'($urandom_range(0, 2047)) - 1024);
        end
    endtask

    initial begin
        int pat[6];
        int n_acc;
        int k;
        bit v;
        bit s;
        pat = '{1, 0, 0, 1, 1, 0};

        // Reset with busy, nonzero inputs: everything must read 0
        rstn = 1'b0;
        model_reset();
        drive(1, 1, 300, -200, 500, -400);
        repeat (3) tick("reset");
        rstn = 1'b1;
        drive(0, 0, 300, -200, 500, -400);
        repeat (2) tick("post_reset");

        // Full block of identical beats shows the twiddle sequence
        for (int i = 0; i < BLK; i++) begin
            drive(1, 0, 7, -3, 100, 50);
            tick("twiddle_seq");
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick("twiddle_flush");

        // Floor behaviour of the 45-degree group with diff = (-1, 0)
        for (int i = 0; i < BLK; i++) begin
            drive(1, 0, 5, 6, (i >= 12) ? -1 : 33, (i >= 12) ? 0 : -17);
            tick("floor");
        end

        // Most negative inputs through every group
        for (int i = 0; i < BLK; i++) begin
            drive(1, 0, -1024, 1023, -1024, -1024);
            tick("extremes");
        end
        drive(0, 0, 1, 1, 1, 1);
        repeat (2) tick("extremes_flush");

        // Gapped valid: counter only moves on accepted beats
        n_acc = 0;
        k     = 0;
        while (n_acc < BLK) begin
            v = bit'(pat[k % 6]);
            drive(v, 0, 7, -3, 100, 50);
            tick("gapped");
            n_acc += int'(v);
            k++;
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick("gapped_flush");

        // Start of block on accepted beat 6 restarts the group sequence
        for (int i = 0; i < BLK; i++) begin
            drive(1, (i == 6), 7, -3, 100, 50);
            tick("resync");
        end

        // Reset mid-block drops in-flight beats
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 7, -3, 100, 50);
            tick("pre_midreset");
        end
        rstn = 1'b0;
        model_reset();
        drive(1, 0, 7, -3, 100, 50);
        tick("midreset");
        rstn = 1'b1;
        drive(0, 0, 7, -3, 100, 50);
        repeat (3) tick("post_midreset");
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 7, -3, 100, 50);
            tick("after_midreset");
        end

        // Random traffic with occasional start-of-block beats
        repeat (300) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 19) == 0);
            drive_rand(v, s);
            tick("random");
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick("random_flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
